// File: rtl/register_file_32x32_pkg.sv
// ============================================================================
// Module      : register_file_32x32_pkg
// Description : Shared ISA-fixed constants and types for the MIPS register file
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package register_file_32x32_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] regidx_t;

endpackage : register_file_32x32_pkg

`default_nettype wire

// File: rtl/register_file_32x32_decoder_5to32.sv
// ============================================================================
// Module      : decoder_5to32
// Description : Gate-level 5-to-32 one-hot write decoder with enable
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module decoder_5to32
    import register_file_32x32_pkg::*;
(
    input  logic                 en_i,
    input  logic [ADDR_W-1:0]    addr_i,
    output logic [REG_COUNT-1:0] onehot_o
);

    logic [3:0] w_hi;
    logic [7:0] w_lo;

    // Upper 2-to-4 stage carries the enable so a disabled write clears every line.
    generate
        for (genvar h = 0; h < 4; h++) begin : g_hi
            localparam logic [1:0] c_h = 2'(h);
            assign w_hi[h] = en_i
                           & (addr_i[4] ~^ c_h[1])
                           & (addr_i[3] ~^ c_h[0]);
        end

        for (genvar l = 0; l < 8; l++) begin : g_lo
            localparam logic [2:0] c_l = 3'(l);
            assign w_lo[l] = (addr_i[2] ~^ c_l[2])
                           & (addr_i[1] ~^ c_l[1])
                           & (addr_i[0] ~^ c_l[0]);
        end

        for (genvar h = 0; h < 4; h++) begin : g_row
            for (genvar l = 0; l < 8; l++) begin : g_col
                assign onehot_o[h*8 + l] = w_hi[h] & w_lo[l];
            end
        end
    endgenerate

endmodule : decoder_5to32

`default_nettype wire

// File: rtl/register_file_32x32.sv
// ============================================================================
// Module      : register_file_32x32
// Description : 32x32 MIPS register file, one write port, two async read ports
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module register_file_32x32
    import register_file_32x32_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    logic [REG_COUNT-1:0] w_we;
    word_t                w_reg [REG_COUNT];

    decoder_5to32 u_decoder (
        .en_i     (reg_write),
        .addr_i   (write_addr),
        .onehot_o (w_we)
    );

    generate
        for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
            if (i == int'(ZERO_REG)) begin : g_zero
                // $zero has no storage; its decoder line is intentionally dropped.
                logic w_unused_we;
                assign w_unused_we = w_we[i];
                assign w_reg[i]    = '0;
            end else begin : g_cell
                word_t r_cell_q;
                word_t w_cell_d;

                // Hold/load mux, then AND with ~reset so reset wins over a write.
                assign w_cell_d = (({DATA_W{w_we[i]}}  & write_data)
                                 | ({DATA_W{~w_we[i]}} & r_cell_q))
                                 & {DATA_W{~reset}};

                always_ff @(posedge clk) begin
                    r_cell_q <= w_cell_d;
                end

                assign w_reg[i] = r_cell_q;
            end
        end
    endgenerate

    word_t w_grp1 [4];
    word_t w_grp2 [4];

    // Four 8:1 first-level stages per port, then a 4:1 final stage.
    generate
        for (genvar g = 0; g < 4; g++) begin : g_grp
            assign w_grp1[g] = w_reg[{2'(g), read_addr1[2:0]}];
            assign w_grp2[g] = w_reg[{2'(g), read_addr2[2:0]}];
        end
    endgenerate

    assign read_data1 = w_grp1[read_addr1[4:3]];
    assign read_data2 = w_grp2[read_addr2[4:3]];

endmodule : register_file_32x32

`default_nettype wire
